// File: rtl/cordic_mul_k_norm_sched_pkg.sv
// rtl/cordic_mul_k_norm_sched_pkg.sv - shared widths, channel enum and stage payload for the K-product normaliser
// Contents:
//   PROD_W / MANT_W / SHIFT_W / MAX_SHIFT  datapath widths and largest usable shift
//   NORM_EXP_W / NORM_TAG_W                exponent and tag widths carried in the stage payload
//   ch_e                                   channel id, CH_X = 0, CH_Y = 1
//   stage_t                                stage A payload (prod, exp, sign, tag, ch)
package cordic_norm_pkg;

  localparam int PROD_W     = 48;
  localparam int MANT_W     = 23;
  localparam int SHIFT_W    = 5;
  localparam int MAX_SHIFT  = 31;
  localparam int NORM_EXP_W = 8;
  localparam int NORM_TAG_W = 4;

  typedef enum logic {
    CH_X = 1'b0,
    CH_Y = 1'b1
  } ch_e;

  typedef struct packed {
    logic [PROD_W-1:0]     prod;
    logic [NORM_EXP_W-1:0] exp;
    logic                  sign;
    logic [NORM_TAG_W-1:0] tag;
    ch_e                   ch;
  } stage_t;

endpackage

// File: rtl/cordic_mul_k_norm_sched_if.sv
// rtl/cordic_mul_k_norm_sched_if.sv - request/result bundle between multiplier, normaliser and packer
// Signals:
//   x_* / y_*  per-channel request: valid, ready, prod[47:0], exp, sign, tag
//   out_*      result: valid, ready, ch, mant[22:0], exp, sign, tag, zero
// Modports:
//   master  drives requests and out_ready (multiplier + packer side)
//   slave   the normaliser
interface cordic_mul_k_norm_sched_if
  import cordic_norm_pkg::*;
#(
  parameter int EXP_W = NORM_EXP_W,
  parameter int TAG_W = NORM_TAG_W
);

  logic              x_valid;
  logic              x_ready;
  logic [PROD_W-1:0] x_prod;
  logic [EXP_W-1:0]  x_exp;
  logic              x_sign;
  logic [TAG_W-1:0]  x_tag;

  logic              y_valid;
  logic              y_ready;
  logic [PROD_W-1:0] y_prod;
  logic [EXP_W-1:0]  y_exp;
  logic              y_sign;
  logic [TAG_W-1:0]  y_tag;

  logic              out_valid;
  logic              out_ready;
  logic              out_ch;
  logic [MANT_W-1:0] out_mant;
  logic [EXP_W-1:0]  out_exp;
  logic              out_sign;
  logic [TAG_W-1:0]  out_tag;
  logic              out_zero;

  modport master (
    output x_valid, x_prod, x_exp, x_sign, x_tag,
    output y_valid, y_prod, y_exp, y_sign, y_tag,
    output out_ready,
    input  x_ready, y_ready,
    input  out_valid, out_ch, out_mant, out_exp, out_sign, out_tag, out_zero
  );

  modport slave (
    input  x_valid, x_prod, x_exp, x_sign, x_tag,
    input  y_valid, y_prod, y_exp, y_sign, y_tag,
    input  out_ready,
    output x_ready, y_ready,
    output out_valid, out_ch, out_mant, out_exp, out_sign, out_tag, out_zero
  );

endinterface

// File: rtl/cordic_mul_k_norm_sched_lzc.sv
// rtl/cordic_mul_k_norm_sched_lzc.sv - combinational 48-bit leading-zero counter
// Ports:
//   prod      in  48  value to scan
//   count     out 6   leading zeros (48 when prod is zero)
//   all_zero  out 1   prod == 0
module cordic_norm_lzc
  import cordic_norm_pkg::*;
(
  input  logic [PROD_W-1:0] prod,
  output logic [5:0]        count,
  output logic              all_zero
);

  // Scan upward so the highest set bit is the last to write the count.
  always_comb begin
    count = 6'(PROD_W);
    for (int i = 0; i < PROD_W; i++) begin
      if (prod[i]) count = 6'(PROD_W - 1 - i);
    end
  end

  assign all_zero = ~|prod;

endmodule

// File: rtl/cordic_mul_k_norm_sched_shift.sv
// rtl/cordic_mul_k_norm_sched_shift.sv - 48-to-23 normalising left shifter with guard bit
// Ports:
//   prod   in  48  K-product
//   shift  in  5   left shift amount
//   mant   out 23  prod[46-shift : 24-shift], zero-filled below bit 0
//   guard  out 1   prod[23-shift], 0 when that index is negative
module cordic_norm_shift
  import cordic_norm_pkg::*;
(
  input  logic [PROD_W-1:0]  prod,
  input  logic [SHIFT_W-1:0] shift,
  output logic [MANT_W-1:0]  mant,
  output logic               guard
);

  logic [PROD_W-1:0] shifted;
  logic              unused_bits;

  assign shifted     = prod << shift;
  // Bit 47 is the hidden one after normalisation; bits below the guard are discarded.
  assign mant        = shifted[46:24];
  assign guard       = shifted[23];
  assign unused_bits = ^{shifted[47], shifted[22:0]};

endmodule

// File: rtl/cordic_mul_k_norm_sched.sv
// rtl/cordic_mul_k_norm_sched.sv - shared X/Y K-product normaliser with round-robin arbitration
// Ports:
//   clk  in  clock
//   rst  in  asynchronous reset, active-high
//   bus  slave modport of cordic_mul_k_norm_sched_if (x_*, y_* requests, out_* result)
// Build option:
//   CORDIC_NORM_ROUND_EN  round half-up on the guard bit; undefined = truncate
module cordic_mul_k_norm_sched
  import cordic_norm_pkg::*;
#(
  parameter int EXP_W = NORM_EXP_W,
  parameter int TAG_W = NORM_TAG_W
) (
  input  logic                        clk,
  input  logic                        rst,
  cordic_mul_k_norm_sched_if.slave    bus
);

  // Stage A: capture register
  stage_t a_q, a_d;
  logic   a_valid_q;
  ch_e    rr_q;             // last granted channel

  // Stage B: output register
  logic              out_valid_q;
  logic              out_ch_q;
  logic [MANT_W-1:0] out_mant_q;
  logic [EXP_W-1:0]  out_exp_q;
  logic              out_sign_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic              out_zero_q;

  logic grant_x, grant_y, b_advance, a_accept, x_rdy, y_rdy, fire;

  assign b_advance = !out_valid_q || bus.out_ready;
  assign a_accept  = !a_valid_q || b_advance;

  // Contention goes to the channel that was not granted last.
  assign grant_x = bus.x_valid && (!bus.y_valid || rr_q == CH_Y);
  assign grant_y = bus.y_valid && (!bus.x_valid || rr_q == CH_X);
  assign x_rdy   = grant_x && a_accept && !rst;
  assign y_rdy   = grant_y && a_accept && !rst;
  assign fire    = x_rdy || y_rdy;

  always_comb begin
    a_d = '0;
    if (grant_y) begin
      a_d.prod = bus.y_prod;
      a_d.exp  = bus.y_exp;
      a_d.sign = bus.y_sign;
      a_d.tag  = bus.y_tag;
      a_d.ch   = CH_Y;
    end else begin
      a_d.prod = bus.x_prod;
      a_d.exp  = bus.x_exp;
      a_d.sign = bus.x_sign;
      a_d.tag  = bus.x_tag;
      a_d.ch   = CH_X;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_q       <= '0;
      rr_q      <= CH_Y;
    end else begin
      if (a_accept) begin
        a_valid_q <= fire;
        if (fire) a_q <= a_d;
      end
      if (fire) rr_q <= a_d.ch;
    end
  end

  // Stage B datapath
  logic [5:0]         lz;
  logic               all_zero;
  logic [SHIFT_W-1:0] s;
  logic [MANT_W-1:0]  mant_sh, b_mant;
  logic               guard;
  logic [EXP_W-1:0]   b_exp;
  logic               b_zero;

  cordic_norm_lzc u_lzc (
    .prod     (a_q.prod),
    .count    (lz),
    .all_zero (all_zero)
  );

  assign s = lz[SHIFT_W-1:0];

  cordic_norm_shift u_shift (
    .prod  (a_q.prod),
    .shift (s),
    .mant  (mant_sh),
    .guard (guard)
  );

  always_comb begin
    b_mant = mant_sh;
    b_exp  = EXP_W'(a_q.exp) - EXP_W'(s);
    b_zero = 1'b0;
`ifdef CORDIC_NORM_ROUND_EN
    if (guard) begin
      // Carry out of an all-ones mantissa renormalises to 1.0 x 2^(exp+1).
      if (&mant_sh) begin
        b_mant = '0;
        b_exp  = b_exp + EXP_W'(1);
      end else begin
        b_mant = mant_sh + MANT_W'(1);
      end
    end
`endif
    // Flush overrides rounding: too small to normalise, or exponent would reach zero.
    if (all_zero || lz > 6'(MAX_SHIFT) || EXP_W'(a_q.exp) <= EXP_W'(s)) begin
      b_zero = 1'b1;
      b_mant = '0;
      b_exp  = '0;
    end
  end

`ifndef CORDIC_NORM_ROUND_EN
  logic unused_guard;
  assign unused_guard = guard;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_sign_q  <= 1'b0;
      out_tag_q   <= '0;
      out_zero_q  <= 1'b0;
    end else if (b_advance) begin
      out_valid_q <= a_valid_q;
      if (a_valid_q) begin
        out_ch_q   <= a_q.ch;
        out_mant_q <= b_mant;
        out_exp_q  <= b_exp;
        out_sign_q <= a_q.sign;
        out_tag_q  <= TAG_W'(a_q.tag);
        out_zero_q <= b_zero;
      end
    end
  end

  assign bus.x_ready   = x_rdy;
  assign bus.y_ready   = y_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_mant  = out_mant_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_sign  = out_sign_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_zero  = out_zero_q;

endmodule

// File: tb/tb_cordic_mul_k_norm_sched.sv
// tb/tb_cordic_mul_k_norm_sched.sv - scoreboard bench for cordic_mul_k_norm_sched (honours CORDIC_NORM_ROUND_EN)
module tb_cordic_mul_k_norm_sched;

  logic clk;
  logic rst;

  cordic_mul_k_norm_sched_if #(.EXP_W(8), .TAG_W(4)) bus ();

  cordic_mul_k_norm_sched #(.EXP_W(8), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ch;
    logic [22:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic [3:0]  tag;
    logic        zero;
  } res_t;

  res_t sb[$];
  res_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic res_t model(input logic ch, input logic [47:0] p, input logic [7:0] e,
                                 input logic sg, input logic [3:0] t);
    res_t        r;
    int          msb;
    int          sh;
    logic [47:0] norm;
    r.ch = ch; r.sign = sg; r.tag = t; r.zero = 1'b0;
    msb = -1;
    for (int i = 0; i < 48; i++) if (p[i]) msb = i;
    sh = 47 - msb;
    if (msb < 16 || int'(e) <= sh) begin
      r.zero = 1'b1; r.mant = '0; r.exp = '0;
    end else begin
      norm   = p << sh;
      r.mant = norm[46:24];
      r.exp  = e - 8'(sh);
`ifdef CORDIC_NORM_ROUND_EN
      if (norm[23]) begin
        if (&r.mant) begin
          r.mant = '0;
          r.exp  = r.exp + 8'd1;
        end else begin
          r.mant = r.mant + 23'd1;
        end
      end
`endif
    end
    return r;
  endfunction

  // Scoreboard: push on every accepted request, pop on every accepted result.
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("one_grant", bus.x_ready & bus.y_ready, 0);
      if (bus.x_valid && bus.x_ready)
        sb.push_back(model(1'b0, bus.x_prod, bus.x_exp, bus.x_sign, bus.x_tag));
      if (bus.y_valid && bus.y_ready)
        sb.push_back(model(1'b1, bus.y_prod, bus.y_exp, bus.y_sign, bus.y_tag));
      if (bus.out_valid && bus.out_ready) begin
        check_eq("sb_empty", sb.size() == 0, 0);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_eq("sb_ch",   bus.out_ch,   mon_e.ch);
          check_eq("sb_mant", bus.out_mant, mon_e.mant);
          check_eq("sb_exp",  bus.out_exp,  mon_e.exp);
          check_eq("sb_sign", bus.out_sign, mon_e.sign);
          check_eq("sb_tag",  bus.out_tag,  mon_e.tag);
          check_eq("sb_zero", bus.out_zero, mon_e.zero);
        end
      end
    end
  end

  task automatic send(input logic ch, input logic [47:0] p, input logic [7:0] e,
                      input logic sg, input logic [3:0] t);
    bit got = 0;
    int n   = 0;
    if (ch) begin
      bus.y_prod = p; bus.y_exp = e; bus.y_sign = sg; bus.y_tag = t; bus.y_valid = 1'b1;
    end else begin
      bus.x_prod = p; bus.x_exp = e; bus.x_sign = sg; bus.x_tag = t; bus.x_valid = 1'b1;
    end
    while (!got && n < 20) begin
      @(negedge clk);
      got = ch ? (bus.y_valid && bus.y_ready) : (bus.x_valid && bus.x_ready);
      @(posedge clk); #1;
      n++;
    end
    bus.x_valid = 1'b0;
    bus.y_valid = 1'b0;
    check_eq("send_accept", got, 1);
  endtask

  task automatic check_out(input string nm, input logic ch, input logic [22:0] m,
                           input logic [7:0] e, input logic sg, input logic z);
    check_eq({nm, "_valid"}, bus.out_valid, 1);
    check_eq({nm, "_ch"},    bus.out_ch,    ch);
    check_eq({nm, "_mant"},  bus.out_mant,  m);
    check_eq({nm, "_exp"},   bus.out_exp,   e);
    check_eq({nm, "_sign"},  bus.out_sign,  sg);
    check_eq({nm, "_zero"},  bus.out_zero,  z);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] rnd_prod();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0] >> $urandom_range(0, 40);
  endfunction

  task automatic stream(input int cycles);
    bit ax, ay;
    bus.x_valid = 1'b1;
    bus.y_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      ax = bus.x_valid && bus.x_ready;
      ay = bus.y_valid && bus.y_ready;
      @(posedge clk); #1;
      if (ax) begin
        bus.x_tag = bus.x_tag + 4'd1; bus.x_prod = rnd_prod();
        bus.x_exp = 8'($urandom_range(1, 255)); bus.x_sign = 1'($urandom);
      end
      if (ay) begin
        bus.y_tag = bus.y_tag + 4'd1; bus.y_prod = rnd_prod();
        bus.y_exp = 8'($urandom_range(1, 255)); bus.y_sign = 1'($urandom);
      end
    end
    bus.x_valid = 1'b0;
    bus.y_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ax, ay;
    rst = 1'b1;
    bus.x_valid = 1'b1; bus.x_prod = '0; bus.x_exp = '0; bus.x_sign = 1'b0; bus.x_tag = '0;
    bus.y_valid = 1'b1; bus.y_prod = '0; bus.y_exp = '0; bus.y_sign = 1'b0; bus.y_tag = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_x_ready",   bus.x_ready,   0);
    check_eq("rst_y_ready",   bus.y_ready,   0);
    check_eq("rst_out_mant",  bus.out_mant,  0);
    check_eq("rst_out_exp",   bus.out_exp,   0);
    bus.x_valid = 1'b0;
    bus.y_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single X, leading one already at bit 47; latency through both stages
    send(1'b0, 48'h8000_0000_0000, 8'd130, 1'b0, 4'd1);
    check_eq("lat_stage_a", bus.out_valid, 0);
    @(posedge clk); #1;
    check_out("x_norm", 1'b0, 23'h0, 8'd130, 1'b0, 1'b0);
    drain();

    // Y, leading one at bit 31 -> shift 16
    send(1'b1, 48'h0000_C000_0000, 8'd100, 1'b1, 4'd2);
    @(posedge clk); #1;
    check_out("y_s16", 1'b1, 23'h40_0000, 8'd84, 1'b1, 1'b0);
    drain();

    // Both held valid: grants must alternate X,Y,X,Y,X,Y
    bus.x_prod = 48'h0123_4567_89AB; bus.x_exp = 8'd60; bus.x_tag = 4'd3;
    bus.y_prod = 48'h0000_0F00_1234; bus.y_exp = 8'd70; bus.y_tag = 4'd8;
    bus.x_valid = 1'b1; bus.y_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ax = bus.x_valid && bus.x_ready;
      ay = bus.y_valid && bus.y_ready;
      check_eq("rr_x_ready", ax, (i % 2) == 0);
      check_eq("rr_y_ready", ay, (i % 2) == 1);
      @(posedge clk); #1;
      if (ax) bus.x_tag = bus.x_tag + 4'd1;
      if (ay) bus.y_tag = bus.y_tag + 4'd1;
    end
    bus.x_valid = 1'b0; bus.y_valid = 1'b0;
    drain();

    // Flush cases
    send(1'b0, 48'h0, 8'd77, 1'b1, 4'd4);
    @(posedge clk); #1;
    check_out("zero_prod", 1'b0, 23'h0, 8'd0, 1'b1, 1'b1);
    send(1'b0, 48'h0000_0000_8000, 8'd77, 1'b0, 4'd5);
    @(posedge clk); #1;
    check_out("lz32", 1'b0, 23'h0, 8'd0, 1'b0, 1'b1);
    send(1'b1, 48'h0020_0000_0000, 8'd5, 1'b1, 4'd6);
    @(posedge clk); #1;
    check_out("uflow", 1'b1, 23'h0, 8'd0, 1'b1, 1'b1);
    send(1'b1, 48'h0020_0000_0000, 8'd10, 1'b0, 4'd7);
    @(posedge clk); #1;
    check_out("uflow_eq", 1'b1, 23'h0, 8'd0, 1'b0, 1'b1);
    send(1'b0, 48'h0020_0000_0000, 8'd11, 1'b0, 4'd8);
    @(posedge clk); #1;
    check_out("exp_min", 1'b0, 23'h0, 8'd1, 1'b0, 1'b0);
    send(1'b0, 48'h0000_0001_8000, 8'd40, 1'b0, 4'd9);
    @(posedge clk); #1;
    check_out("lz31", 1'b0, 23'h40_0000, 8'd9, 1'b0, 1'b0);
    drain();

    // Back-pressure with both channels streaming
    fork
      stream(16);
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_x_ready", bus.x_ready, 0);
        check_eq("bp_y_ready", bus.y_ready, 0);
        check_eq("bp_out_valid", bus.out_valid, 1);
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset while stage B holds a result
    bus.out_ready = 1'b0;
    send(1'b0, 48'h4000_0000_0000, 8'd90, 1'b0, 4'd7);
    @(posedge clk); #1;
    check_eq("pre_rst_valid", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_valid", bus.out_valid, 0);
    check_eq("async_rst_tag",   bus.out_tag,   0);
    sb.delete();
    bus.out_ready = 1'b1;
    bus.x_prod = 48'h0000_FFFF_0000; bus.x_exp = 8'd200; bus.x_tag = 4'd11;
    bus.y_prod = 48'h1234_5678_9ABC; bus.y_exp = 8'd20;  bus.y_tag = 4'd12;
    bus.x_valid = 1'b1; bus.y_valid = 1'b1;
    check_eq("rst_held_x_ready", bus.x_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_x_first", bus.x_ready, 1);
    check_eq("post_rst_y_wait",  bus.y_ready, 0);
    @(posedge clk); #1;
    bus.x_valid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_y_next", bus.y_ready, 1);
    @(posedge clk); #1;
    bus.y_valid = 1'b0;
    drain();

    // Guard-bit rounding (carry-out) or truncation, depending on build
    send(1'b1, 48'hFFFF_FF80_0000, 8'd50, 1'b0, 4'd13);
    @(posedge clk); #1;
`ifdef CORDIC_NORM_ROUND_EN
    check_out("round_carry", 1'b1, 23'h0, 8'd51, 1'b0, 1'b0);
`else
    check_out("trunc_ones", 1'b1, 23'h7F_FFFF, 8'd50, 1'b0, 1'b0);
`endif
    drain();

    check_eq("sb_final_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_mul_k_norm_sched.md
Name: cordic_mul_K_norm_sched

Overview:
- Shares one normalisation left-shifter (48-bit K-product in, 5-bit shift, 23-bit mantissa out) between the X and Y channels of the floating-point CORDIC gain-compensation stage.
- Round-robin arbitration between the two channels, leading-zero count to derive the shift, exponent adjust, zero/underflow flush.
- Two-stage valid/ready pipeline; sits between the mantissa multiplier and result packing.

Parameters:
EXP_W, 8, exponent width (biased)
TAG_W, 4, opaque tag carried with each operand

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
x_valid  in  1  channel 0 request
x_ready  out  1  channel 0 accepted this cycle
x_prod  in  48  channel 0 mantissa product, leading-one nominal at bit 47
x_exp  in  EXP_W  channel 0 exponent for leading one at bit 47
x_sign  in  1  channel 0 sign
x_tag  in  TAG_W  channel 0 tag
y_valid, y_ready, y_prod, y_exp, y_sign, y_tag  same as above for channel 1
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_ch  out  1  source channel, 0=X, 1=Y
out_mant  out  23  normalised mantissa, hidden bit dropped
out_exp  out  EXP_W  adjusted exponent
out_sign  out  1  sign
out_tag  out  TAG_W  tag
out_zero  out  1  result flushed to zero

Behaviour:
- Reset is asynchronous and active-high. While rst is high: all stage valids = 0, out_* = 0, x_ready = y_ready = 0, rr pointer = 1 (so X wins first).
- Stage A (capture) accepts when it is empty or stage B will advance. Stage B (output register) advances when !out_valid || out_ready.
- Arbitration:
  - Only one valid: that channel is granted.
  - Both valid: the channel opposite the rr pointer (last-granted channel) is granted.
  - x_ready / y_ready = grant && stage A can accept; combinational from the valids, no combinational path from out_ready beyond the stall term.
  - rr pointer updates only on an accepted transfer.
- Stage A registers prod, exp, sign, tag and ch.
- Stage B computes:
  - lz = leading-zero count of prod[47:0].
  - prod == 0 or lz > 31: out_zero = 1, mant = 0, exp = 0.
  - Otherwise s = lz[4:0]. The shifter yields mant = prod[46-s : 24-s], zero-filled below bit 0.
  - out_exp = exp - s. If exp <= s (underflow), out_zero = 1, mant = 0, exp = 0.
  - sign and tag pass through unchanged; sign is kept on zero.
- Latency and throughput:
  - Accept to out_valid: 2 cycles.
  - Throughput: 1 result/cycle with out_ready held high.
  - Under back-pressure, both stages hold and x_ready / y_ready drop, with no loss or duplication.
- Ordering: results leave in acceptance order.
- rst asserted mid-operation drops in-flight data immediately.
- A request held while not granted must stay stable; the block does not require this but tests drive it so.

Optional Feature:
- CORDIC_NORM_ROUND_EN defined:
  - Stage B also takes guard bit g = prod[23-s] (0 when 23-s < 0) and rounds half-up: mant = mant + g.
  - Mantissa carry-out sets mant = 0 and out_exp + 1.
  - No rounding on zero/underflow results.
- Undefined: truncation only, no guard logic.
- Latency is 2 cycles in both builds.

Decomposition:
- Package cordic_norm_pkg holds:
  - PROD_W = 48, MANT_W = 23, SHIFT_W = 5, MAX_SHIFT = 31.
  - Channel enum CH_X = 0 / CH_Y = 1.
  - Stage payload struct (prod, exp, sign, tag, ch).
- Sub-module cordic_norm_lzc: 48-bit leading-zero counter, combinational, 6-bit count plus all-zero flag.
- The existing 48→23 left-shifter is instantiated once inside stage B.

Test Plan:
- Single X request, prod = 48'h8000_0000_0000, exp = 8'd130, out_ready = 1 → 2 cycles later: out_ch = 0, mant = 0, exp = 130, out_zero = 0.
- Y prod = 48'h0000_C000_0000 (leading one at bit 31, s = 16), exp = 100 → mant = 23'h40_0000, exp = 84.
- X and Y held valid for 6 cycles, out_ready = 1 → grants X,Y,X,Y,X,Y; each channel's ready strictly alternates.
- prod = 0, and separately prod = 48'h0000_0000_8000 (lz = 32) → out_zero = 1, mant = 0, exp = 0. exp = 5 with s = 10 → underflow → out_zero = 1.
- out_ready low 4 cycles with both channels streaming → x_ready = y_ready = 0 after stages fill. Release → data resumes in order, no drop or duplicate (tag sequence check).
- rst pulsed while stage B is valid → out_valid = 0 asynchronously. First post-reset grant goes to X. With CORDIC_NORM_ROUND_EN: prod = 48'hFFFF_FF80_0000, exp = 50 → mant = 0, exp = 51.
